// File: rtl/mem_wb_pipe_reg.sv
// MEM/WB pipeline register for the 5-stage RV32 core.
// Captures MEM-stage results with valid tracking, hold on stall and bubble
// insertion on flush. It also produces the write-back value and the gated
// register-file write strobe, and keeps a one-cycle-delayed copy of the last
// write for WB-to-ID forwarding. A counter tracks retired instructions.
module mem_wb_pipe_reg #(
    parameter int DATA_W    = 32,
    parameter int REG_IDX_W = 5,
    parameter int WBSEL_W   = 2,
    parameter int CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 in_valid,
    input  logic [DATA_W-1:0]    data_mem_in,
    input  logic [DATA_W-1:0]    data_alu_in,
    input  logic [DATA_W-1:0]    pc_in,
    input  logic [REG_IDX_W-1:0] rd_in,
    input  logic [WBSEL_W-1:0]   wbsel_in,
    input  logic                 regwrite_in,
    output logic                 out_valid,
    output logic [REG_IDX_W-1:0] rd_out,
    output logic [DATA_W-1:0]    pc_out,
    output logic [WBSEL_W-1:0]   wbsel_out,
    output logic [DATA_W-1:0]    wb_data,
    output logic                 wb_we,
    output logic                 prev_we,
    output logic [REG_IDX_W-1:0] prev_rd,
    output logic [DATA_W-1:0]    prev_data,
    output logic [CNT_W-1:0]     retire_count
);

    logic                 r_valid;
    logic                 r_regwrite;
    logic [DATA_W-1:0]    r_data_mem;
    logic [DATA_W-1:0]    r_data_alu;
    logic [DATA_W-1:0]    r_pc;
    logic [REG_IDX_W-1:0] r_rd;
    logic [WBSEL_W-1:0]   r_wbsel;
    logic [CNT_W-1:0]     r_retire;

    logic                 r_prev_we;
    logic [REG_IDX_W-1:0] r_prev_rd;
    logic [DATA_W-1:0]    r_prev_data;

    logic [DATA_W-1:0]    w_pc_plus4;
    logic [DATA_W-1:0]    w_wb_data;
    logic                 w_wb_we;

    // Stage registers: reset beats flush, flush beats stall, stall beats load.
    // Flush only needs to kill valid and the write intent; the payload is don't-care.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_regwrite <= 1'b0;
            r_data_mem <= '0;
            r_data_alu <= '0;
            r_pc       <= '0;
            r_rd       <= '0;
            r_wbsel    <= '0;
            r_retire   <= '0;
        end else if (flush) begin
            r_valid    <= 1'b0;
            r_regwrite <= 1'b0;
        end else if (!stall) begin
            r_valid    <= in_valid;
            r_regwrite <= regwrite_in;
            r_data_mem <= data_mem_in;
            r_data_alu <= data_alu_in;
            r_pc       <= pc_in;
            r_rd       <= rd_in;
            r_wbsel    <= wbsel_in;
            if (in_valid) begin
                r_retire <= r_retire + CNT_W'(1);
            end
        end
    end

    // Forwarding copy of the last write; it keeps tracking during a stall,
    // so after one held cycle it mirrors the held entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev_we   <= 1'b0;
            r_prev_rd   <= '0;
            r_prev_data <= '0;
        end else begin
            r_prev_we   <= w_wb_we;
            r_prev_rd   <= r_rd;
            r_prev_data <= w_wb_data;
        end
    end

    assign w_pc_plus4 = r_pc + DATA_W'(4);

    // Write-back source select; codes above 2 return zero.
    always_comb begin
        w_wb_data = '0;
        if (r_wbsel == WBSEL_W'(0)) begin
            w_wb_data = r_data_alu;
        end else if (r_wbsel == WBSEL_W'(1)) begin
            w_wb_data = r_data_mem;
        end else if (r_wbsel == WBSEL_W'(2)) begin
            w_wb_data = w_pc_plus4;
        end
    end

    // x0 is hardwired to zero, so writes to it are suppressed here.
    assign w_wb_we = r_valid & r_regwrite & (r_rd != '0);

    assign out_valid    = r_valid;
    assign rd_out       = r_rd;
    assign pc_out       = r_pc;
    assign wbsel_out    = r_wbsel;
    assign wb_data      = w_wb_data;
    assign wb_we        = w_wb_we;
    assign prev_we      = r_prev_we;
    assign prev_rd      = r_prev_rd;
    assign prev_data    = r_prev_data;
    assign retire_count = r_retire;

endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
// Directed bench for mem_wb_pipe_reg: the default-width instance plus a
// CNT_W=4 instance that shares the stimulus and is used for counter wrap.
module tb_mem_wb_pipe_reg;

    logic        clk = 1'b0;
    logic        rst, stall, flush, in_valid, regwrite_in;
    logic [31:0] data_mem_in, data_alu_in, pc_in;
    logic [4:0]  rd_in;
    logic [1:0]  wbsel_in;

    logic        out_valid, wb_we, prev_we;
    logic [4:0]  rd_out, prev_rd;
    logic [31:0] pc_out, wb_data, prev_data, retire_count;
    logic [1:0]  wbsel_out;

    logic        s_out_valid, s_wb_we, s_prev_we;
    logic [4:0]  s_rd_out, s_prev_rd;
    logic [31:0] s_pc_out, s_wb_data, s_prev_data;
    logic [1:0]  s_wbsel_out;
    logic [3:0]  s_retire_count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_wb_pipe_reg dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
        .data_mem_in(data_mem_in), .data_alu_in(data_alu_in), .pc_in(pc_in),
        .rd_in(rd_in), .wbsel_in(wbsel_in), .regwrite_in(regwrite_in),
        .out_valid(out_valid), .rd_out(rd_out), .pc_out(pc_out), .wbsel_out(wbsel_out),
        .wb_data(wb_data), .wb_we(wb_we), .prev_we(prev_we), .prev_rd(prev_rd),
        .prev_data(prev_data), .retire_count(retire_count)
    );

    mem_wb_pipe_reg #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
        .data_mem_in(data_mem_in), .data_alu_in(data_alu_in), .pc_in(pc_in),
        .rd_in(rd_in), .wbsel_in(wbsel_in), .regwrite_in(regwrite_in),
        .out_valid(s_out_valid), .rd_out(s_rd_out), .pc_out(s_pc_out), .wbsel_out(s_wbsel_out),
        .wb_data(s_wb_data), .wb_we(s_wb_we), .prev_we(s_prev_we), .prev_rd(s_prev_rd),
        .prev_data(s_prev_data), .retire_count(s_retire_count)
    );

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] mem,
                         input logic [31:0] pc, input logic [4:0] rd,
                         input logic [1:0] sel, input logic rw);
        in_valid    = v;
        data_alu_in = alu;
        data_mem_in = mem;
        pc_in       = pc;
        rd_in       = rd;
        wbsel_in    = sel;
        regwrite_in = rw;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; flush = 1'b0;
        drive(1'b1, 32'h5555_5555, 32'h6666_6666, 32'h80, 5'd7, 2'd1, 1'b1);
        step(); step();
        rst = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 2'd0, 1'b0);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%h exp=0", out_valid); end
        checks++; if (wb_data !== 32'h0) begin failures++; $display("FAIL reset_wb_data got=%h exp=0", wb_data); end
        checks++; if (wb_we !== 1'b0) begin failures++; $display("FAIL reset_wb_we got=%h exp=0", wb_we); end
        checks++; if ({rd_out, pc_out, wbsel_out} !== 39'h0) begin failures++; $display("FAIL reset_regs got rd=%h pc=%h sel=%h exp=0", rd_out, pc_out, wbsel_out); end
        checks++; if ({prev_we, prev_rd, prev_data} !== 38'h0) begin failures++; $display("FAIL reset_prev got we=%h rd=%h data=%h exp=0", prev_we, prev_rd, prev_data); end
        checks++; if (retire_count !== 32'd0 || s_retire_count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d/%0d exp=0", retire_count, s_retire_count); end
    endtask

    task automatic test_load();
        drive(1'b1, 32'h0000_1234, 32'h0, 32'h40, 5'd5, 2'd0, 1'b1);
        step();
        drive(1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 2'd0, 1'b0);
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL load_valid got=%h exp=1", out_valid); end
        checks++; if (wb_data !== 32'h1234) begin failures++; $display("FAIL load_wb_data got=%h exp=1234", wb_data); end
        checks++; if (wb_we !== 1'b1) begin failures++; $display("FAIL load_wb_we got=%h exp=1", wb_we); end
        checks++; if (retire_count !== 32'd1) begin failures++; $display("FAIL load_count got=%0d exp=1", retire_count); end
        checks++; if (rd_out !== 5'd5 || pc_out !== 32'h40) begin failures++; $display("FAIL load_rd_pc got rd=%0d pc=%h exp 5/40", rd_out, pc_out); end
        step();
        // previous entry forwarded; the bubble just loaded is invalid and uncounted
        checks++; if (prev_we !== 1'b1 || prev_rd !== 5'd5 || prev_data !== 32'h1234) begin failures++; $display("FAIL load_prev got we=%h rd=%0d data=%h exp 1/5/1234", prev_we, prev_rd, prev_data); end
        checks++; if (out_valid !== 1'b0 || wb_we !== 1'b0) begin failures++; $display("FAIL invalid_load got v=%h we=%h exp 0/0", out_valid, wb_we); end
        checks++; if (retire_count !== 32'd1) begin failures++; $display("FAIL invalid_count got=%0d exp=1", retire_count); end
    endtask

    task automatic test_mux();
        logic [1:0]  sel_tab [4] = '{2'd1, 2'd2, 2'd3, 2'd2};
        logic [31:0] pc_tab  [4] = '{32'h100, 32'h100, 32'h100, 32'hFFFF_FFFC};
        logic [31:0] exp_tab [4] = '{32'hDEAD_BEEF, 32'h104, 32'h0, 32'h0};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 32'h11, 32'hDEAD_BEEF, pc_tab[i], 5'd7, sel_tab[i], 1'b1);
            step();
            checks++; if (wb_data !== exp_tab[i]) begin failures++; $display("FAIL mux_%0d got=%h exp=%h", i, wb_data, exp_tab[i]); end
        end
        checks++; if (retire_count !== 32'd5) begin failures++; $display("FAIL mux_count got=%0d exp=5", retire_count); end
    endtask

    task automatic test_x0();
        drive(1'b1, 32'h99, 32'h0, 32'h200, 5'd0, 2'd0, 1'b1);
        step();
        checks++; if (out_valid !== 1'b1 || wb_we !== 1'b0) begin failures++; $display("FAIL x0_we got v=%h we=%h exp 1/0", out_valid, wb_we); end
        checks++; if (retire_count !== 32'd6) begin failures++; $display("FAIL x0_count got=%0d exp=6", retire_count); end
    endtask

    task automatic test_stall();
        drive(1'b1, 32'h0000_AAAA, 32'h0, 32'h300, 5'd3, 2'd0, 1'b1);
        step();
        checks++; if (rd_out !== 5'd3 || retire_count !== 32'd7) begin failures++; $display("FAIL stall_load got rd=%0d cnt=%0d exp 3/7", rd_out, retire_count); end
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h0000_BBBB + i, 32'h0, 32'h400, 5'd9, 2'd0, 1'b1);
            step();
            checks++; if (rd_out !== 5'd3 || wb_data !== 32'hAAAA || pc_out !== 32'h300 || wb_we !== 1'b1) begin failures++; $display("FAIL stall_hold_%0d got rd=%0d data=%h pc=%h we=%h exp 3/aaaa/300/1", i, rd_out, wb_data, pc_out, wb_we); end
            checks++; if (retire_count !== 32'd7) begin failures++; $display("FAIL stall_count_%0d got=%0d exp=7", i, retire_count); end
            checks++; if (prev_rd !== 5'd3 || prev_data !== 32'hAAAA) begin failures++; $display("FAIL stall_prev_%0d got rd=%0d data=%h exp 3/aaaa", i, prev_rd, prev_data); end
        end
        stall = 1'b0;
        step();
        checks++; if (rd_out !== 5'd9 || wb_data !== 32'hBBBD || retire_count !== 32'd8) begin failures++; $display("FAIL stall_release got rd=%0d data=%h cnt=%0d exp 9/bbbd/8", rd_out, wb_data, retire_count); end
    endtask

    task automatic test_flush();
        drive(1'b1, 32'h77, 32'h0, 32'h500, 5'd4, 2'd0, 1'b1);
        flush = 1'b1;
        step();
        checks++; if (out_valid !== 1'b0 || wb_we !== 1'b0 || retire_count !== 32'd8) begin failures++; $display("FAIL flush got v=%h we=%h cnt=%0d exp 0/0/8", out_valid, wb_we, retire_count); end
        // refill, then flush together with stall
        flush = 1'b0;
        step();
        checks++; if (out_valid !== 1'b1 || retire_count !== 32'd9) begin failures++; $display("FAIL flush_refill got v=%h cnt=%0d exp 1/9", out_valid, retire_count); end
        flush = 1'b1; stall = 1'b1;
        step();
        checks++; if (out_valid !== 1'b0 || wb_we !== 1'b0 || retire_count !== 32'd9) begin failures++; $display("FAIL flush_stall got v=%h we=%h cnt=%0d exp 0/0/9", out_valid, wb_we, retire_count); end
        flush = 1'b0; stall = 1'b0;
        step();
        stall = 1'b1;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0; stall = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 2'd0, 1'b0);
        checks++; if ({out_valid, wb_we, rd_out, pc_out, wb_data} !== 71'h0) begin failures++; $display("FAIL rst_in_stall got v=%h we=%h rd=%h pc=%h data=%h exp 0", out_valid, wb_we, rd_out, pc_out, wb_data); end
        checks++; if ({prev_we, prev_rd, prev_data} !== 38'h0 || retire_count !== 32'd0 || s_retire_count !== 4'd0) begin failures++; $display("FAIL rst_in_stall_prev got we=%h rd=%h data=%h cnt=%0d exp 0", prev_we, prev_rd, prev_data, retire_count); end
    endtask

    task automatic test_wrap();
        drive(1'b1, 32'h1, 32'h0, 32'h0, 5'd1, 2'd0, 1'b1);
        for (int i = 1; i <= 17; i++) begin
            step();
            if (i == 15) begin
                checks++; if (s_retire_count !== 4'd15) begin failures++; $display("FAIL wrap_15 got=%0d exp=15", s_retire_count); end
            end
            if (i == 16) begin
                checks++; if (s_retire_count !== 4'd0) begin failures++; $display("FAIL wrap_16 got=%0d exp=0", s_retire_count); end
            end
        end
        checks++; if (s_retire_count !== 4'd1) begin failures++; $display("FAIL wrap_17 got=%0d exp=1", s_retire_count); end
        checks++; if (retire_count !== 32'd17) begin failures++; $display("FAIL wide_17 got=%0d exp=17", retire_count); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_mux();
        test_x0();
        test_stall();
        test_flush();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
